// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU command issuer.
// Holds request/response layouts, field offsets, FSM encoding, MUL codes.
package alu_pkg;

    // REQ_DATA layout, MSB first
    typedef struct packed {
        logic [1:0] inp_valid;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       cin;
        logic       mode;
    } req_t;

    // RSP_DATA layout, MSB first
    typedef struct packed {
        logic [1:0]  tag;
        logic [15:0] res;
        logic        cout;
        logic        oflow;
        logic        g;
        logic        e;
        logic        l;
        logic        err;
    } rsp_t;

    localparam int REQ_W = 24;
    localparam int RSP_W = 24;

    localparam int REQ_IV_LSB   = 22;
    localparam int REQ_OPA_LSB  = 14;
    localparam int REQ_OPB_LSB  = 6;
    localparam int REQ_CMD_LSB  = 2;
    localparam int REQ_CIN_BIT  = 1;
    localparam int REQ_MODE_BIT = 0;

    localparam int RSP_TAG_LSB   = 22;
    localparam int RSP_RES_LSB   = 6;
    localparam int RSP_COUT_BIT  = 5;
    localparam int RSP_OFLOW_BIT = 4;
    localparam int RSP_G_BIT     = 3;
    localparam int RSP_E_BIT     = 2;
    localparam int RSP_L_BIT     = 1;
    localparam int RSP_ERR_BIT   = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] CMD_MUL_A = 4'd9;
    localparam logic [3:0] CMD_MUL_B = 4'd10;

    function automatic logic is_mul(
        input logic       mode,
        input logic [3:0] cmd
    );
        return mode && (cmd == CMD_MUL_A || cmd == CMD_MUL_B);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: DEPTH-entry synchronous FIFO, sync active-high reset.
// Ports: CLK, RST, PUSH/WDATA, POP/RDATA (head), COUNT, FULL, EMPTY.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   PUSH,
    input  logic [W-1:0]           WDATA,
    input  logic                   POP,
    output logic [W-1:0]           RDATA,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   FULL,
    output logic                   EMPTY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    assign FULL    = (cnt == CW'(DEPTH));
    assign EMPTY   = (cnt == '0);
    assign push_ok = PUSH && !FULL;
    assign pop_ok  = POP && !EMPTY;
    assign RDATA   = mem[rptr];
    assign COUNT   = cnt;

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wptr] <= WDATA;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU requests, issues one at a time, waits the
// ALU latency, captures results and returns them with a 2-bit tag.
// Ports: CLK/RST; REQ_* request in; OPA..INP_VALID ALU drive;
// RES..ERR ALU results; RSP_* response out; FIFO_COUNT occupancy.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic [23:0]            REQ_DATA,
    output logic [7:0]             OPA,
    output logic [7:0]             OPB,
    output logic [3:0]             CMD,
    output logic                   CIN,
    output logic                   MODE,
    output logic                   CE,
    output logic [1:0]             INP_VALID,
    input  logic [15:0]            RES,
    input  logic                   COUT,
    input  logic                   OFLOW,
    input  logic                   G,
    input  logic                   E,
    input  logic                   L,
    input  logic                   ERR,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [23:0]            RSP_DATA,
    output logic [$clog2(DEPTH):0] FIFO_COUNT
);

    localparam int LMAX = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int LW   = $clog2(LMAX + 1);

    logic [1:0]    state;
    req_t          drv;
    req_t          head;
    rsp_t          rsp;
    logic [LW-1:0] lat_cnt;
    logic [1:0]    tag;
    logic          ce_q;
    logic          rsp_vld;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [23:0]   head_raw;

    // Popping only from IDLE keeps one command in flight; the
    // registered count means a fresh push is seen a cycle later.
    assign pop = (state == ST_IDLE) && !fifo_empty;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (REQ_VALID),
        .WDATA (REQ_DATA),
        .POP   (pop),
        .RDATA (head_raw),
        .COUNT (FIFO_COUNT),
        .FULL  (fifo_full),
        .EMPTY (fifo_empty)
    );

    assign head      = req_t'(head_raw);
    assign REQ_READY = !fifo_full;

    assign OPA       = drv.opa;
    assign OPB       = drv.opb;
    assign CMD       = drv.cmd;
    assign CIN       = drv.cin;
    assign MODE      = drv.mode;
    assign INP_VALID = drv.inp_valid;
    assign CE        = ce_q;
    assign RSP_VALID = rsp_vld;
    assign RSP_DATA  = rsp;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            drv     <= '0;
            rsp     <= '0;
            lat_cnt <= '0;
            tag     <= '0;
            ce_q    <= 1'b0;
            rsp_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        drv     <= head;
                        ce_q    <= 1'b1;
                        lat_cnt <= is_mul(head.mode, head.cmd)
                                 ? LW'(MUL_LAT) : LW'(ALU_LAT);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // count==1 here is the edge where it reaches zero
                    if (lat_cnt == LW'(1)) begin
                        rsp     <= '{tag:   tag,
                                     res:   RES,
                                     cout:  COUT,
                                     oflow: OFLOW,
                                     g:     G,
                                     e:     E,
                                     l:     L,
                                     err:   ERR};
                        rsp_vld <= 1'b1;
                        ce_q    <= 1'b0;
                        lat_cnt <= '0;
                        state   <= ST_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                ST_HOLD: begin
                    if (RSP_READY) begin
                        rsp_vld <= 1'b0;
                        tag     <= tag + 2'd1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: self-checking bench with a behavioural ALU stub.
// Directed vectors, multi-cycle sequences and a random scoreboard run.
module tb_alu_cmd_issuer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [23:0] REQ_DATA;
    logic [7:0]  OPA;
    logic [7:0]  OPB;
    logic [3:0]  CMD;
    logic        CIN;
    logic        MODE;
    logic        CE;
    logic [1:0]  INP_VALID;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, E, L, ERR;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [23:0] RSP_DATA;
    logic [2:0]  FIFO_COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1), .MUL_LAT(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_DATA(REQ_DATA),
        .OPA(OPA), .OPB(OPB), .CMD(CMD), .CIN(CIN),
        .MODE(MODE), .CE(CE), .INP_VALID(INP_VALID),
        .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
        .G(G), .E(E), .L(L), .ERR(ERR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural ALU: add, or multiply for MODE=1 with CMD 9/10
    function automatic logic [21:0] alu_ref(
        input logic [7:0] a, input logic [7:0] b,
        input logic [3:0] c, input logic m, input logic [1:0] iv);
        logic [15:0] r;
        logic        mul;
        mul = m && (c == 4'd9 || c == 4'd10);
        if (mul) r = {8'h00, a} * {8'h00, b};
        else     r = {8'h00, a} + {8'h00, b};
        return {r, r[8], 1'b0, a > b, a == b, a < b, iv == 2'b00};
    endfunction

    assign {RES, COUT, OFLOW, G, E, L, ERR} =
        alu_ref(OPA, OPB, CMD, MODE, INP_VALID);

    function automatic logic [23:0] mk(
        input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
        input logic [3:0] c, input logic ci, input logic m);
        return {iv, a, b, c, ci, m};
    endfunction

    function automatic logic [21:0] ref_of(input logic [23:0] q);
        return alu_ref(q[21:14], q[13:6], q[5:2], q[0], q[23:22]);
    endfunction

    function automatic logic [23:0] drv_bus();
        return {INP_VALID, OPA, OPB, CMD, CIN, MODE};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_DATA  = '0;
        RSP_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
    endtask

    // Offer one request for one edge; call and return at a negedge
    task automatic offer(input logic [23:0] d, output bit acc);
        REQ_VALID = 1'b1;
        REQ_DATA  = d;
        acc       = REQ_READY;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_ce(output int n);
        n = 0;
        while (!CE && n < 50) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        while (!RSP_VALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic ack();
        RSP_READY = 1'b1;
        @(posedge CLK);
        #1 RSP_READY = 1'b0;
        @(negedge CLK);
    endtask

    typedef struct {
        logic [23:0] req;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t        vecs [6];
    logic [23:0] q_req [$];
    logic [1:0]  q_tag [$];

    initial begin
        bit          acc;
        int          n;
        int          naccept;
        bit          stable;
        logic [23:0] snap_rsp;
        logic [23:0] snap_drv;
        logic [23:0] b2b [6];
        logic [23:0] r;
        logic [1:0]  t;
        int          acc_idx;

        vecs[0] = '{mk(2'b11, 8'h05, 8'h03, 4'd0, 1'b0, 1'b1), 16'h0008, 1'b0, 1};
        vecs[1] = '{mk(2'b11, 8'd20, 8'd13, 4'd9, 1'b0, 1'b1), 16'd260, 1'b0, 2};
        vecs[2] = '{mk(2'b11, 8'hff, 8'hff, 4'd10, 1'b0, 1'b1), 16'hfe01, 1'b0, 2};
        vecs[3] = '{mk(2'b11, 8'h10, 8'h20, 4'd9, 1'b0, 1'b0), 16'h0030, 1'b0, 1};
        vecs[4] = '{mk(2'b00, 8'hff, 8'h01, 4'd3, 1'b1, 1'b1), 16'h0100, 1'b1, 1};
        vecs[5] = '{mk(2'b10, 8'h80, 8'h80, 4'd10, 1'b1, 1'b0), 16'h0100, 1'b0, 1};

        do_reset();
        chk("rst_rsp_valid", 32'(RSP_VALID), 0);
        chk("rst_count", 32'(FIFO_COUNT), 0);
        chk("rst_ce", 32'(CE), 0);
        chk("rst_ready", 32'(REQ_READY), 1);
        chk("rst_rsp_data", 32'(RSP_DATA), 0);
        chk("rst_drive", 32'(drv_bus()), 0);

        // Directed vectors, one request at a time
        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].req, acc);
            chk($sformatf("v%0d_accept", i), 32'(acc), 1);
            chk($sformatf("v%0d_no_bypass", i), 32'(CE), 0);
            wait_ce(n);
            chk($sformatf("v%0d_ce_delay", i), n, 1);
            chk($sformatf("v%0d_drive", i), 32'(drv_bus()),
                32'(vecs[i].req));
            wait_rv(n);
            chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
            chk($sformatf("v%0d_ce_off", i), 32'(CE), 0);
            chk($sformatf("v%0d_res", i), 32'(RSP_DATA[21:6]),
                32'(vecs[i].res));
            chk($sformatf("v%0d_err", i), 32'(RSP_DATA[0]),
                32'(vecs[i].err));
            chk($sformatf("v%0d_tag", i), 32'(RSP_DATA[23:22]), i % 4);
            ack();
            chk($sformatf("v%0d_rv_clear", i), 32'(RSP_VALID), 0);
        end

        // Back-to-back burst with the response stalled
        do_reset();
        naccept = 0;
        for (int i = 0; i < 6; i++) begin
            b2b[i] = mk(2'b11, 8'(i + 1), 8'h10, 4'd0, 1'b0, 1'b0);
            offer(b2b[i], acc);
            if (acc) naccept++;
        end
        chk("b2b_accepted", naccept, 5);
        chk("b2b_count", 32'(FIFO_COUNT), 4);
        chk("b2b_ready", 32'(REQ_READY), 0);
        chk("b2b_rsp_valid", 32'(RSP_VALID), 1);
        chk("b2b_rsp0", 32'(RSP_DATA), 32'({2'd0, ref_of(b2b[0])}));

        snap_rsp = RSP_DATA;
        snap_drv = drv_bus();
        stable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (RSP_DATA !== snap_rsp || drv_bus() !== snap_drv ||
                CE !== 1'b0 || RSP_VALID !== 1'b1 ||
                REQ_READY !== 1'b0)
                stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 1);
        chk("hold_drive", 32'(snap_drv), 32'(b2b[0]));

        ack();
        @(negedge CLK);
        chk("b2b_ready_after", 32'(REQ_READY), 1);
        chk("b2b_count_after", 32'(FIFO_COUNT), 3);

        // Remaining queued entries: tags continue 1,2,3,0
        for (int k = 1; k < 5; k++) begin
            wait_rv(n);
            chk($sformatf("seq%0d_valid", k), 32'(RSP_VALID), 1);
            chk($sformatf("seq%0d_rsp", k), 32'(RSP_DATA),
                32'({2'(k % 4), ref_of(b2b[k])}));
            ack();
        end

        // Reset during WAIT with two entries queued
        do_reset();
        offer(mk(2'b11, 8'd20, 8'd13, 4'd9, 1'b0, 1'b1), acc);
        offer(mk(2'b11, 8'd1, 8'd2, 4'd0, 1'b0, 1'b0), acc);
        offer(mk(2'b11, 8'd3, 8'd4, 4'd0, 1'b0, 1'b0), acc);
        chk("mid_ce", 32'(CE), 1);
        chk("mid_count", 32'(FIFO_COUNT), 2);
        chk("mid_rv", 32'(RSP_VALID), 0);
        RST       = 1'b1;
        REQ_VALID = 1'b1;
        REQ_DATA  = mk(2'b11, 8'd7, 8'd7, 4'd0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("abort_rv", 32'(RSP_VALID), 0);
        chk("abort_count", 32'(FIFO_COUNT), 0);
        chk("abort_ce", 32'(CE), 0);
        chk("abort_drive", 32'(drv_bus()), 0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b0 || CE !== 1'b0) stable = 1'b0;
        end
        chk("abort_quiet", 32'(stable), 1);
        r = mk(2'b01, 8'd9, 8'd6, 4'd1, 1'b1, 1'b0);
        offer(r, acc);
        wait_rv(n);
        chk("abort_next_rsp", 32'(RSP_DATA), 32'({2'd0, ref_of(r)}));
        ack();

        // Random traffic against an in-order scoreboard
        do_reset();
        acc_idx = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            REQ_VALID = ($urandom_range(0, 99) < 55);
            REQ_DATA  = mk(2'($urandom), 8'($urandom), 8'($urandom),
                           ($urandom_range(0, 2) == 0)
                             ? (($urandom_range(0, 1) == 1) ? 4'd9 : 4'd10)
                             : 4'($urandom),
                           1'($urandom), 1'($urandom));
            RSP_READY = (cyc < 1300) ? ($urandom_range(0, 99) < 40) : 1'b1;
            if (cyc >= 1200) REQ_VALID = 1'b0;
            if (REQ_VALID && REQ_READY) begin
                q_req.push_back(REQ_DATA);
                q_tag.push_back(2'(acc_idx));
                acc_idx++;
            end
            if (RSP_VALID && RSP_READY) begin
                if (q_req.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    r = q_req.pop_front();
                    t = q_tag.pop_front();
                    chk("rnd_rsp", 32'(RSP_DATA), 32'({t, ref_of(r)}));
                    chk("rnd_drive", 32'(drv_bus()), 32'(r));
                end
            end
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        RSP_READY = 1'b0;
        chk("rnd_drained", q_req.size(), 0);
        chk("rnd_count_end", 32'(FIFO_COUNT), 0);
        chk("rnd_traffic", 32'(acc_idx > 50), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
